// File: rtl/input_output.sv
// Press-to-pulse converter: one registered 1-cycle pulse per accepted rising edge of `in`,
// with an optional debounce filter. Define INPUT_OUTPUT_RELEASE_PULSE_EN to also pulse on release.
module input_output #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Two-bit encoding leaves spare codes so the default branch is reachable.
  typedef enum logic [1:0] {
    NOT_PRESSED = 2'b00,
    PRESSED     = 2'b01
  } state_t;

  state_t          state;
  state_t          state_d;
  logic            next_out;
  logic            filt_q;
  logic            filt_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  // The FSM sees the level the filter is about to accept, so with DEBOUNCE_CYCLES=1 the
  // pulse follows the first high sample directly and with N it follows the Nth.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (in != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state;
    next_out = 1'b0;
    case (state)
      NOT_PRESSED: begin
        if (filt_d) begin
          state_d  = PRESSED;
          next_out = 1'b1;
        end
      end
      PRESSED: begin
        if (!filt_d) begin
          state_d = NOT_PRESSED;
`ifdef INPUT_OUTPUT_RELEASE_PULSE_EN
          next_out = 1'b1;
`else
          next_out = 1'b0;
`endif
        end
      end
      default: begin
        state_d  = NOT_PRESSED;
        next_out = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= NOT_PRESSED;
      out    <= 1'b0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      state  <= state_d;
      out    <= next_out;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: tb/tb_input_output.sv
// Bench for input_output: one shared stimulus stream drives a DEBOUNCE_CYCLES=1 and a
// DEBOUNCE_CYCLES=4 instance; per-cycle expected levels go into queues checked by a monitor.
module tb_input_output;

`ifdef INPUT_OUTPUT_RELEASE_PULSE_EN
  localparam logic R = 1'b1;
`else
  localparam logic R = 1'b0;
`endif

  logic clk;
  logic reset;
  logic in;
  logic out1;
  logic out4;

  logic [0:0] exp1_q[$];
  logic [0:0] exp4_q[$];
  int         step_q[$];
  int         n_cmp;
  int         n_bad;
  int         step_no;

  input_output #(.DEBOUNCE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .in(in), .out(out1));
  input_output #(.DEBOUNCE_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .in(in), .out(out4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs for one edge, queue what each DUT must show after it
  task automatic step(input logic rst, input logic lvl, input logic e1, input logic e4);
    @(negedge clk);
    reset = rst;
    in    = lvl;
    step_no++;
    exp1_q.push_back(e1);
    exp4_q.push_back(e4);
    step_q.push_back(step_no);
  endtask

  task automatic hold(input logic lvl, input int n, input logic [7:0] e1, input logic [7:0] e4);
    for (int i = 0; i < n; i++) step(1'b0, lvl, e1[i], e4[i]);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp1_q.size() > 0) begin
      logic [0:0] e1;
      logic [0:0] e4;
      int         s;
      e1 = exp1_q.pop_front();
      e4 = exp4_q.pop_front();
      s  = step_q.pop_front();
      n_cmp++;
      if (out1 !== e1) begin
        n_bad++;
        $display("FAIL out_dc1 step %0d: got %b expected %b", s, out1, e1);
      end
      n_cmp++;
      if (out4 !== e4) begin
        n_bad++;
        $display("FAIL out_dc4 step %0d: got %b expected %b", s, out4, e4);
      end
    end
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    step_no = 0;
    reset   = 1'b1;
    in      = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0);                    // reset, out 0 after the edge
    hold(1'b0, 4, 8'b0000, 8'b0000);                 // idle low
    hold(1'b1, 4, 8'b0001, 8'b1000);                 // press: dc1 at once, dc4 on 4th sample
    hold(1'b0, 4, {7'b0, R}, {4'b0, R, 3'b0});       // release
    hold(1'b1, 4, 8'b0001, 8'b1000);                 // second press
    step(1'b1, 1'b1, 1'b0, 1'b0);                    // reset while pressed
    hold(1'b1, 4, 8'b0001, 8'b1000);                 // still high after reset: new press
    hold(1'b0, 4, {7'b0, R}, {4'b0, R, 3'b0});
    hold(1'b1, 3, 8'b001, 8'b000);                   // 3-sample glitch: dc4 ignores it
    hold(1'b0, 4, {7'b0, R}, 8'b0000);
    hold(1'b1, 6, 8'b000001, 8'b001000);             // long press: single pulse
    hold(1'b0, 4, {7'b0, R}, {4'b0, R, 3'b0});
    step(1'b1, 1'b1, 1'b0, 1'b0);                    // reset on the would-be pulse edge
    hold(1'b1, 4, 8'b0001, 8'b1000);
    hold(1'b0, 4, {7'b0, R}, {4'b0, R, 3'b0});
    hold(1'b1, 4, 8'b0001, 8'b1000);
    step(1'b0, 1'b0, R, 1'b0);                       // 1-sample dropout while pressed
    hold(1'b1, 3, 8'b001, 8'b000);                   // dc1 re-presses, dc4 never left
    hold(1'b0, 4, {7'b0, R}, {4'b0, R, 3'b0});

    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp1_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp1_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp1_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
